// File: rtl/snake_head_engine.sv
// Snake head position register with wrap/wall handling and a raster plotter
// that streams the BLOCK x BLOCK pixels of the head cell one per clock.
module snake_head_engine #(
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int BLOCK  = 4,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int X_INIT = 50,
  parameter int Y_INIT = 30,
  parameter int WRAP   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          update,
  input  logic [1:0]    dir,
  input  logic          plot_start,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          pix_valid,
  output logic          busy,
  output logic          plot_done,
  output logic          hit_wall
);

  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int CW  = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] D_LEFT  = 2'b00;
  localparam logic [1:0] D_RIGHT = 2'b01;
  localparam logic [1:0] D_UP    = 2'b10;
  localparam logic [1:0] D_DOWN  = 2'b11;

  localparam logic [XW:0]   STEP_X = XW1'(BLOCK);
  localparam logic [YW:0]   STEP_Y = YW1'(BLOCK);
  localparam logic [XW:0]   LIM_X  = XW1'(X_MAX + 1 - BLOCK);
  localparam logic [YW:0]   LIM_Y  = YW1'(Y_MAX + 1 - BLOCK);
  localparam logic [CW-1:0] LAST   = CW'(BLOCK - 1);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] head_x_q, head_x_d, base_x_q, base_x_d, x_out_q, x_out_d;
  logic [YW-1:0] head_y_q, head_y_d, base_y_q, base_y_d, y_out_q, y_out_d;
  logic [1:0]    last_dir_q, last_dir_d;
  logic          hit_q, hit_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;

  logic [1:0]    eff_dir;
  logic [XW:0]   x_inc, x_dec;
  logic [YW:0]   y_inc, y_dec;
  logic [XW-1:0] mv_x;
  logic [YW-1:0] mv_y;
  logic          mv_hit;

  // Candidate move, computed one bit wider so under/overflow is visible.
  always_comb begin
    eff_dir = ((dir[1] == last_dir_q[1]) && (dir[0] != last_dir_q[0])) ? last_dir_q : dir;
    x_inc   = {1'b0, head_x_q} + STEP_X;
    x_dec   = {1'b0, head_x_q} - STEP_X;
    y_inc   = {1'b0, head_y_q} + STEP_Y;
    y_dec   = {1'b0, head_y_q} - STEP_Y;
    mv_x    = head_x_q;
    mv_y    = head_y_q;
    mv_hit  = 1'b0;
    case (eff_dir)
      D_LEFT: begin
        if (!x_dec[XW])     mv_x   = x_dec[XW-1:0];
        else if (WRAP != 0) mv_x   = LIM_X[XW-1:0];
        else                mv_hit = 1'b1;
      end
      D_RIGHT: begin
        if (WRAP != 0)          mv_x   = ({1'b0, head_x_q} >= LIM_X) ? '0 : x_inc[XW-1:0];
        else if (x_inc > LIM_X) mv_hit = 1'b1;
        else                    mv_x   = x_inc[XW-1:0];
      end
      D_UP: begin
        if (!y_dec[YW])     mv_y   = y_dec[YW-1:0];
        else if (WRAP != 0) mv_y   = LIM_Y[YW-1:0];
        else                mv_hit = 1'b1;
      end
      default: begin
        if (WRAP != 0)          mv_y   = ({1'b0, head_y_q} >= LIM_Y) ? '0 : y_inc[YW-1:0];
        else if (y_inc > LIM_Y) mv_hit = 1'b1;
        else                    mv_y   = y_inc[YW-1:0];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    last_dir_d = last_dir_q;
    hit_d      = hit_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    col_d      = col_q;
    row_d      = row_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    if (ld) begin
      head_x_d   = XW'(X_INIT);
      head_y_d   = YW'(Y_INIT);
      last_dir_d = D_RIGHT;
      hit_d      = 1'b0;
      state_d    = S_IDLE;
      col_d      = '0;
      row_d      = '0;
    end else begin
      if (update && (state_q == S_IDLE) && !hit_q) begin
        head_x_d   = mv_x;
        head_y_d   = mv_y;
        hit_d      = mv_hit;
        last_dir_d = eff_dir;
      end
      case (state_q)
        S_IDLE: begin
          // A same-cycle update outranks the plot request.
          if (plot_start && !update) begin
            state_d  = S_DRAW;
            base_x_d = head_x_q;
            base_y_d = head_y_q;
            col_d    = '0;
            row_d    = '0;
            x_out_d  = head_x_q;
            y_out_d  = head_y_q;
          end
        end
        S_DRAW: begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          if (state_d == S_DRAW) begin
            x_out_d = base_x_q + XW'(col_d);
            y_out_d = base_y_q + YW'(row_d);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      head_x_q   <= '0;
      head_y_q   <= '0;
      last_dir_q <= D_RIGHT;
      hit_q      <= 1'b0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_out_q    <= '0;
      y_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      last_dir_q <= last_dir_d;
      hit_q      <= hit_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign hit_wall  = hit_q;
  assign pix_valid = (state_q == S_DRAW);
  assign busy      = (state_q != S_IDLE);
  assign plot_done = (state_q == S_DONE);

endmodule

// File: tb/tb_snake_head_engine.sv
// Bench for snake_head_engine: a toroidal instance (A) and a walled instance (B)
// share stimulus; a behavioural model feeds head and pixel scoreboards.
module tb_snake_head_engine;

  logic       clk = 1'b0;
  logic       reset, ld, update, plot_start;
  logic [1:0] dir;

  logic [7:0] a_hx, a_xo, b_hx, b_xo;
  logic [6:0] a_hy, a_yo, b_hy, b_yo;
  logic       a_pv, a_busy, a_pd, a_hit;
  logic       b_pv, b_busy, b_pd, b_hit;

  int n_tests = 0;
  int n_fail  = 0;

  int mx[2], my[2], mlast[2], mhit[2];
  int wrap_m[2] = '{1, 0};
  int xi[2]     = '{50, 148};
  int yi[2]     = '{30, 8};

  typedef struct { int x; int y; int hit; } head_t;
  typedef struct { int x; int y; } pix_t;
  head_t hq[$];
  pix_t  pq[$];

  snake_head_engine dut_a (
    .clk(clk), .reset(reset), .ld(ld), .update(update), .dir(dir), .plot_start(plot_start),
    .head_x(a_hx), .head_y(a_hy), .x_out(a_xo), .y_out(a_yo),
    .pix_valid(a_pv), .busy(a_busy), .plot_done(a_pd), .hit_wall(a_hit)
  );

  snake_head_engine #(.WRAP(0), .X_INIT(148), .Y_INIT(8)) dut_b (
    .clk(clk), .reset(reset), .ld(ld), .update(update), .dir(dir), .plot_start(plot_start),
    .head_x(b_hx), .head_y(b_hy), .x_out(b_xo), .y_out(b_yo),
    .pix_valid(b_pv), .busy(b_busy), .plot_done(b_pd), .hit_wall(b_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mlast[i] = 1; mhit[i] = 0;
    end
  endfunction

  function automatic void model_ld();
    for (int i = 0; i < 2; i++) begin
      mx[i] = xi[i]; my[i] = yi[i]; mlast[i] = 1; mhit[i] = 0;
    end
  endfunction

  // Board 160x120, 4-pixel cells: last legal cell origin is x=156, y=116.
  function automatic void model_update(int i, int d);
    int ed;
    if (mhit[i] != 0) return;
    ed = d;
    if ((d == 0 && mlast[i] == 1) || (d == 1 && mlast[i] == 0) ||
        (d == 2 && mlast[i] == 3) || (d == 3 && mlast[i] == 2)) ed = mlast[i];
    mlast[i] = ed;
    case (ed)
      0: if (mx[i] < 4) begin if (wrap_m[i] != 0) mx[i] = 156; else mhit[i] = 1; end
         else mx[i] = mx[i] - 4;
      1: if (wrap_m[i] != 0) mx[i] = (mx[i] >= 156) ? 0 : mx[i] + 4;
         else if (mx[i] + 4 > 156) mhit[i] = 1;
         else mx[i] = mx[i] + 4;
      2: if (my[i] < 4) begin if (wrap_m[i] != 0) my[i] = 116; else mhit[i] = 1; end
         else my[i] = my[i] - 4;
      default: if (wrap_m[i] != 0) my[i] = (my[i] >= 116) ? 0 : my[i] + 4;
         else if (my[i] + 4 > 116) mhit[i] = 1;
         else my[i] = my[i] + 4;
    endcase
  endfunction

  // Drives one accepted update and queues both instances' expected heads.
  task automatic drive_update(input logic [1:0] d);
    dir = d;
    update = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_update(i, int'(d));
      hq.push_back('{mx[i], my[i], mhit[i]});
    end
    step();
    update = 1'b0;
  endtask

  task automatic do_load();
    ld = 1'b1;
    step();
    ld = 1'b0;
    model_ld();
  endtask

  task automatic test_reset();
    reset = 1'b1; ld = 1'b0; update = 1'b0; plot_start = 1'b0; dir = 2'b00;
    #12;
    n_tests++;
    if ({a_hx, a_hy, a_xo, a_yo, a_pv, a_busy, a_pd, a_hit} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_A: got hx=%0d hy=%0d xo=%0d yo=%0d pv=%b busy=%b pd=%b hit=%b, expected all 0",
               a_hx, a_hy, a_xo, a_yo, a_pv, a_busy, a_pd, a_hit);
    end
    n_tests++;
    if ({b_hx, b_hy, b_xo, b_yo, b_pv, b_busy, b_pd, b_hit} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_B: got hx=%0d hy=%0d xo=%0d yo=%0d pv=%b busy=%b pd=%b hit=%b, expected all 0",
               b_hx, b_hy, b_xo, b_yo, b_pv, b_busy, b_pd, b_hit);
    end
    step();
    reset = 1'b0;
    model_reset();
    step();
    step();
    n_tests++;
    if ({a_hx, a_hy} !== 15'd0) begin
      n_fail++;
      $display("FAIL post_reset_hold: got (%0d,%0d), expected (0,0)", a_hx, a_hy);
    end
  endtask

  task automatic test_load();
    do_load();
    n_tests++;
    if ({a_hx, a_hy, a_pv, a_busy, a_hit} !== {8'd50, 7'd30, 3'b000}) begin
      n_fail++;
      $display("FAIL load_A: got (%0d,%0d) pv=%b busy=%b hit=%b, expected (50,30) pv=0 busy=0 hit=0",
               a_hx, a_hy, a_pv, a_busy, a_hit);
    end
    n_tests++;
    if ({b_hx, b_hy} !== {8'd148, 7'd8}) begin
      n_fail++;
      $display("FAIL load_B: got (%0d,%0d), expected (148,8)", b_hx, b_hy);
    end
  endtask

  task automatic test_move_reversal();
    logic [1:0] seq [3];
    head_t ea, eb;
    seq = '{2'b01, 2'b00, 2'b00};
    for (int k = 0; k < 3; k++) begin
      drive_update(seq[k]);
      ea = hq.pop_front();
      eb = hq.pop_front();
      n_tests++;
      if ({a_hx, a_hy, a_hit} !== {ea.x[7:0], ea.y[6:0], ea.hit[0]}) begin
        n_fail++;
        $display("FAIL move_A[%0d]: got (%0d,%0d,hit=%b), expected (%0d,%0d,hit=%0d)",
                 k, a_hx, a_hy, a_hit, ea.x, ea.y, ea.hit);
      end
      n_tests++;
      if ({b_hx, b_hy, b_hit} !== {eb.x[7:0], eb.y[6:0], eb.hit[0]}) begin
        n_fail++;
        $display("FAIL move_B[%0d]: got (%0d,%0d,hit=%b), expected (%0d,%0d,hit=%0d)",
                 k, b_hx, b_hy, b_hit, eb.x, eb.y, eb.hit);
      end
    end
    n_tests++;
    if (a_hx !== 8'd62) begin
      n_fail++;
      $display("FAIL reversal_keeps_right: got head_x=%0d, expected 62", a_hx);
    end
  endtask

  task automatic test_wall();
    head_t ea, eb;
    n_tests++;
    if ({b_hx, b_hit} !== {8'd156, 1'b1}) begin
      n_fail++;
      $display("FAIL wall_hit: got head_x=%0d hit=%b, expected 156 hit=1", b_hx, b_hit);
    end
    drive_update(2'b11);
    ea = hq.pop_front();
    eb = hq.pop_front();
    n_tests++;
    if ({a_hx, a_hy} !== {ea.x[7:0], ea.y[6:0]}) begin
      n_fail++;
      $display("FAIL down_A: got (%0d,%0d), expected (%0d,%0d)", a_hx, a_hy, ea.x, ea.y);
    end
    n_tests++;
    if ({b_hx, b_hy, b_hit} !== {8'd156, 7'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL wall_sticky: got (%0d,%0d,hit=%b), expected (156,8,hit=1) [model %0d,%0d]",
               b_hx, b_hy, b_hit, eb.x, eb.y);
    end
    do_load();
    n_tests++;
    if ({b_hx, b_hy, b_hit} !== {8'd148, 7'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL wall_ld_clear: got (%0d,%0d,hit=%b), expected (148,8,hit=0)", b_hx, b_hy, b_hit);
    end
  endtask

  task automatic test_wrap();
    head_t ea, eb;
    int k;
    k = 0;
    while (mx[0] != 156 && k < 100) begin
      drive_update(2'b01);
      ea = hq.pop_front();
      eb = hq.pop_front();
      n_tests++;
      if ({a_hx, a_hy, b_hx, b_hy, b_hit} !== {ea.x[7:0], ea.y[6:0], eb.x[7:0], eb.y[6:0], eb.hit[0]}) begin
        n_fail++;
        $display("FAIL walk_right[%0d]: got A(%0d,%0d) B(%0d,%0d,%b), expected A(%0d,%0d) B(%0d,%0d,%0d)",
                 k, a_hx, a_hy, b_hx, b_hy, b_hit, ea.x, ea.y, eb.x, eb.y, eb.hit);
      end
      k++;
    end
    n_tests++;
    if (a_hx !== 8'd156) begin
      n_fail++;
      $display("FAIL reach_156: got head_x=%0d after %0d moves, expected 156", a_hx, k);
    end
    drive_update(2'b01);
    void'(hq.pop_front());
    void'(hq.pop_front());
    n_tests++;
    if (a_hx !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_right: got head_x=%0d, expected 0", a_hx);
    end
    k = 0;
    while (my[0] != 0 && k < 100) begin
      drive_update(2'b11);
      ea = hq.pop_front();
      void'(hq.pop_front());
      n_tests++;
      if ({a_hx, a_hy} !== {ea.x[7:0], ea.y[6:0]}) begin
        n_fail++;
        $display("FAIL walk_down[%0d]: got (%0d,%0d), expected (%0d,%0d)", k, a_hx, a_hy, ea.x, ea.y);
      end
      k++;
    end
    n_tests++;
    if (a_hy !== 7'd0) begin
      n_fail++;
      $display("FAIL wrap_down: got head_y=%0d, expected 0", a_hy);
    end
    drive_update(2'b01);
    drive_update(2'b10);
    hq.delete();
    n_tests++;
    if ({a_hx, a_hy} !== {8'd4, 7'd116}) begin
      n_fail++;
      $display("FAIL wrap_up: got (%0d,%0d), expected (4,116)", a_hx, a_hy);
    end
  endtask

  task automatic test_plot();
    pix_t e;
    int busy_cnt, pv_cnt, pd_cnt;
    bit ended;
    do_load();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pq.push_back('{xi[0] + c, yi[0] + r});
    plot_start = 1'b1;
    step();
    plot_start = 1'b0;
    busy_cnt = 0; pv_cnt = 0; pd_cnt = 0; ended = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!a_busy) begin
        ended = 1'b1;
        break;
      end
      busy_cnt++;
      if (a_pv) begin
        pv_cnt++;
        if (pq.size() != 0) begin
          e = pq.pop_front();
          n_tests++;
          if ({a_xo, a_yo} !== {e.x[7:0], e.y[6:0]}) begin
            n_fail++;
            $display("FAIL pixel[%0d]: got (%0d,%0d), expected (%0d,%0d)", pv_cnt - 1, a_xo, a_yo, e.x, e.y);
          end
        end
      end
      if (a_pd) begin
        pd_cnt++;
        n_tests++;
        if (a_pv !== 1'b0) begin
          n_fail++;
          $display("FAIL done_pv: got pix_valid=%b during plot_done, expected 0", a_pv);
        end
      end
      if (c == 3) begin
        dir = 2'b11;
        update = 1'b1;
      end else begin
        update = 1'b0;
      end
      step();
    end
    update = 1'b0;
    n_tests++;
    if (!ended || busy_cnt != 17 || pv_cnt != 16 || pd_cnt != 1 || pq.size() != 0) begin
      n_fail++;
      $display("FAIL plot_counts: got ended=%b busy=%0d pix=%0d done=%0d left=%0d, expected 1/17/16/1/0",
               ended, busy_cnt, pv_cnt, pd_cnt, pq.size());
    end
    pq.delete();
    n_tests++;
    if ({a_hx, a_hy} !== {8'd50, 7'd30}) begin
      n_fail++;
      $display("FAIL update_while_busy: got (%0d,%0d), expected (50,30)", a_hx, a_hy);
    end
    n_tests++;
    if ({a_xo, a_yo} !== {8'd53, 7'd33}) begin
      n_fail++;
      $display("FAIL out_hold: got (%0d,%0d), expected (53,33)", a_xo, a_yo);
    end
  endtask

  task automatic test_priority();
    do_load();
    drive_update(2'b11);
    hq.delete();
    ld = 1'b1; update = 1'b1; plot_start = 1'b1; dir = 2'b11;
    step();
    ld = 1'b0; update = 1'b0; plot_start = 1'b0;
    model_ld();
    n_tests++;
    if ({a_hx, a_hy, a_busy} !== {8'd50, 7'd30, 1'b0}) begin
      n_fail++;
      $display("FAIL ld_priority: got (%0d,%0d) busy=%b, expected (50,30) busy=0", a_hx, a_hy, a_busy);
    end
    update = 1'b1; plot_start = 1'b1; dir = 2'b11;
    model_update(0, 3);
    step();
    update = 1'b0; plot_start = 1'b0;
    n_tests++;
    if ({a_hx, a_hy, a_busy} !== {8'(mx[0]), 7'(my[0]), 1'b0}) begin
      n_fail++;
      $display("FAIL update_priority: got (%0d,%0d) busy=%b, expected (%0d,%0d) busy=0",
               a_hx, a_hy, a_busy, mx[0], my[0]);
    end
  endtask

  task automatic test_reset_mid_plot();
    int pd_seen;
    do_load();
    plot_start = 1'b1;
    step();
    plot_start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    n_tests++;
    if ({a_pv, a_xo, a_yo} !== {1'b1, 8'd51, 7'd31}) begin
      n_fail++;
      $display("FAIL draw6_state: got pv=%b (%0d,%0d), expected pv=1 (51,31)", a_pv, a_xo, a_yo);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({a_pv, a_busy, a_pd, a_xo, a_yo} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset: got pv=%b busy=%b pd=%b xo=%0d yo=%0d before any edge, expected all 0",
               a_pv, a_busy, a_pd, a_xo, a_yo);
    end
    pd_seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (a_pd || b_pd) pd_seen++;
    end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      if (a_pd || b_pd) pd_seen++;
    end
    n_tests++;
    if (pd_seen != 0 || a_busy !== 1'b0 || {a_hx, a_hy} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_no_done: got done_pulses=%0d busy=%b head=(%0d,%0d), expected 0/0/(0,0)",
               pd_seen, a_busy, a_hx, a_hy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_move_reversal();
    test_wall();
    test_wrap();
    test_plot();
    test_priority();
    test_reset_mid_plot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_head_engine.md
SNAKE_HEAD_ENGINE -- requirements
Module: snake_head_engine

Interface
REQ-001 SHALL have parameter XW, default 8, meaning width of the x coordinate.
REQ-002 SHALL have parameter YW, default 7, meaning width of the y coordinate.
REQ-003 SHALL have parameter BLOCK, default 4, meaning cell edge in pixels (legal 1..8) and the move step size.
REQ-004 SHALL have parameters X_MAX, default 159, and Y_MAX, default 119, meaning the last visible pixel column and row.
REQ-005 SHALL have parameters X_INIT, default 50, and Y_INIT, default 30, meaning the head load position.
REQ-006 SHALL have parameter WRAP, default 1, meaning 1 = toroidal board and 0 = walls.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port ld, input, 1 bit: load the head to (X_INIT, Y_INIT).
REQ-010 SHALL have port update, input, 1 bit: move the head one cell.
REQ-011 SHALL have port dir, input, 2 bits: 00 left, 01 right, 10 up (y-), 11 down (y+).
REQ-012 SHALL have port plot_start, input, 1 bit: request drawing of the head cell.
REQ-013 SHALL have ports head_x / head_y, output, XW / YW bits: current head position.
REQ-014 SHALL have ports x_out / y_out, output, XW / YW bits: pixel coordinate being drawn.
REQ-015 SHALL have port pix_valid, output, 1 bit: x_out/y_out valid this cycle.
REQ-016 SHALL have port busy, output, 1 bit: plot sequence in progress.
REQ-017 SHALL have port plot_done, output, 1 bit: one-cycle pulse at end of a plot.
REQ-018 SHALL have port hit_wall, output, 1 bit: sticky wall-collision flag (WRAP=0 only).

Function
REQ-019 Priority SHALL be reset > ld > update > plot_start; lower-priority inputs in the same cycle are ignored.
REQ-020 ld SHALL set head=(X_INIT,Y_INIT), last_dir=01, clear hit_wall, and abort any plot (FSM to IDLE, busy/pix_valid low next cycle).
REQ-021 update SHALL move the head by BLOCK along dir; a dir opposite to last_dir SHALL be replaced by last_dir; last_dir SHALL take the effective direction.
REQ-022 update while busy=1 SHALL be ignored entirely; update while hit_wall=1 SHALL be ignored.
REQ-023 Wrap (WRAP=1): left from x<BLOCK -> X_MAX+1-BLOCK; right from x>=X_MAX+1-BLOCK -> 0; y analogous with Y_MAX.
REQ-024 Walls (WRAP=0): a move that would leave 0..X_MAX+1-BLOCK / 0..Y_MAX+1-BLOCK SHALL hold the position and set hit_wall, sticky until ld or reset.
REQ-025 Arithmetic SHALL be performed at XW+1 / YW+1 bits so that underflow/overflow is detected before truncation.
REQ-026 FSM states SHALL be IDLE, DRAW, DONE; plot_start in IDLE -> DRAW, capturing the head into base registers; plot_start outside IDLE SHALL be ignored.
REQ-027 DRAW SHALL emit BLOCK*BLOCK pixels, one per cycle, with pix_valid=1; the first pixel is in the cycle after plot_start.
REQ-028 Pixel order SHALL be raster order: x_out=base_x+col, y_out=base_y+row, col fastest, both 0..BLOCK-1.
REQ-029 After the last pixel, the FSM SHALL go to DONE for one cycle (plot_done=1, pix_valid=0), then to IDLE.
REQ-030 busy SHALL be 1 in DRAW and DONE (BLOCK*BLOCK+1 cycles per plot).
REQ-031 x_out/y_out SHALL hold their last value when pix_valid=0.

Reset
REQ-032 reset SHALL asynchronously force head_x=0, head_y=0, x_out=0, y_out=0, pix_valid=0, busy=0, plot_done=0, hit_wall=0, last_dir=01, FSM=IDLE, and all counters to 0, including mid-plot.
REQ-033 After reset deassertion, the head SHALL remain at (0,0) until ld.

Verification
REQ-034 Scenario: reset, then ld -> head=(50,30), pix_valid=0, busy=0, hit_wall=0.
REQ-035 Scenario: from (50,30), update dir=01 -> head_x=54; then update dir=00 (reversal) -> head_x=58, last_dir still 01.
REQ-036 Scenario: WRAP=1, head_x=156, update dir=01 -> head_x=0; update dir=01 then dir=10 from head_y=0 -> head_y=116.
REQ-037 Scenario: WRAP=0, head_x=156, update dir=01 -> head_x=156, hit_wall=1; a further update has no effect; ld clears hit_wall.
REQ-038 Scenario: plot_start at (50,30) -> 16 pix_valid cycles: first (50,30), fifth (50,31), last (53,33); plot_done for 1 cycle after; busy for 17 cycles; an update during busy does not move the head.
REQ-039 Scenario: reset asserted on the 6th DRAW cycle -> pix_valid, busy and x_out go to 0 without waiting for a clock edge; no plot_done pulse.
